if_stage: RTL

Instruction-fetch stage of the GeMIPS five-stage pipeline. It owns the program counter, drives the synchronous instruction RAM and presents each fetched instruction with its PC to the decode stage. It redirects on branches resolved in decode while preserving the MIPS delay slot. During decode stalls it holds the instruction in a one-entry buffer.

---
 rtl/if_stage_pkg.sv | 25 ++
 rtl/if_hold_buf.sv | 28 ++
 rtl/if_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the GeMIPS instruction-fetch stage.
package if_stage_pkg;
    localparam int                XLEN         = 32;
    localparam logic [XLEN-1:0]   RESET_PC_DEF = 32'h8000_0000;
    localparam logic [XLEN-1:0]   NOP_INST     = 32'h0000_0000;
    localparam logic [XLEN-1:0]   INST_BYTES   = 32'd4;
    localparam logic [XLEN-1:0]   WORD_MASK    = 32'h0000_0003;

    // Encoding is {id_valid, hold} so both flags read straight off the state.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b10,
        ST_STALL = 2'b11
    } if_state_e;

    typedef struct packed {
        logic advance;
        logic load_hold;
        logic clr_hold;
    } if_ctrl_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~WORD_MASK;
    endfunction
endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction buffer that keeps the decode word steady across a stall.
module if_hold_buf
    import if_stage_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);
    logic [W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i)       data_d = data_i;
        else if (clear_i) data_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign data_o = data_q;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives the sync instruction RAM, feeds decode
// with a delay-slot-preserving redirect and a one-entry stall buffer.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            branch_flag_i,
    input  logic [XLEN-1:0] target_address_i,
    output logic            inst_ram_en_o,
    output logic [XLEN-1:0] inst_ram_addr_o,
    input  logic [XLEN-1:0] inst_ram_rdata_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o,
    output logic            id_valid_o
);
    if_state_e       state_q, state_d;
    if_ctrl_t        ctrl;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] hold_inst_q;
    logic            en_q;
    logic            id_valid_q, hold_q;

    assign id_valid_q = (state_q != ST_BOOT);
    assign hold_q     = (state_q == ST_STALL);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_BOOT;
        else     state_q <= state_d;
    end

    // BOOT waits for the RAM enable so the first decoded word is really read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  if (en_q && !stall_i) state_d = ST_RUN;
            ST_RUN:   if (stall_i)          state_d = ST_STALL;
            ST_STALL: if (!stall_i)         state_d = ST_RUN;
            default:                        state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        ctrl           = '0;
        ctrl.advance   = en_q && !stall_i;
        ctrl.load_hold = (state_q == ST_RUN) && stall_i;
        ctrl.clr_hold  = !stall_i;
    end

    always_comb begin
        pc_d = pc_q + INST_BYTES;
        if (branch_flag_i) pc_d = align_word(target_address_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            id_pc_q <= '0;
            en_q    <= 1'b0;
        end else begin
            en_q <= 1'b1;
            if (ctrl.advance) begin
                pc_q    <= pc_d;
                id_pc_q <= pc_q;
            end
        end
    end

    if_hold_buf #(.W(XLEN)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ctrl.load_hold),
        .clear_i (ctrl.clr_hold),
        .data_i  (inst_ram_rdata_i),
        .data_o  (hold_inst_q)
    );

    always_comb begin
        id_inst_o = inst_ram_rdata_i;
        if (!id_valid_q)  id_inst_o = NOP_INST;
        else if (hold_q)  id_inst_o = hold_inst_q;
    end

    assign inst_ram_en_o   = en_q;
    assign inst_ram_addr_o = pc_q;
    assign id_pc_o         = id_pc_q;
    assign id_valid_o      = id_valid_q;
endmodule
